// File: rtl/decoder_pkg.sv
// Shared types for the 2-to-4 decoder pipeline: skid-buffer state enum,
// code/line widths, the {en, code} request word and the one-hot decode function.
// Imported by the interface, the skid buffer and the top.
package decoder_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Word carried through the elastic buffer; decoding happens after it.
    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } dec_req_t;

    function automatic logic [LINES-1:0] decode_onehot(input dec_req_t req);
        logic [LINES-1:0] onehot;
        onehot = '0;
        if (req.en) begin
            onehot[req.code] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/decoder2x4_pipe_if.sv
// Handshake bundle for decoder2x4_pipe: input code stream and decoded output stream.
// master = producer/consumer side (drives in_*, out_ready); slave = the decoder.
// Signals: in_valid/in_ready/in_code/in_en, out_valid/out_ready/out_onehot.
interface decoder2x4_pipe_if;
    import decoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_en;
    logic              out_valid;
    logic              out_ready;
    logic [LINES-1:0]  out_onehot;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot
    );

endinterface

// File: rtl/decoder2x4_pipe_skid_buf.sv
// skid_buf: two-entry elastic buffer (EMPTY/ONE/FULL), datapath-agnostic, width W.
// Latency 1 edge from accept to out_vld; in_rdy is a flop (no comb path from out_rdy).
// Backpressure: absorbs one extra word while stalled, then drops in_rdy in FULL.
module skid_buf
    import decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         in_rdy_q, in_rdy_d;
    logic         acc;
    logic         ret;

    assign acc = in_vld && in_rdy_q;
    assign ret = (state_q != EMPTY) && out_rdy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_dat_q  <= '0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_dat_q  <= out_dat_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    // Next-state
    always_comb begin
        state_d    = state_q;
        out_dat_d  = out_dat_q;
        skid_dat_d = skid_dat_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d   = ONE;
                    out_dat_d = in_dat;
                end
            end
            ONE: begin
                if (acc && !ret) begin
                    state_d    = FULL;
                    skid_dat_d = in_dat;
                end else if (acc && ret) begin
                    out_dat_d = in_dat;
                end else if (ret) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_rdy_q is low here, so no accept can coincide.
                if (ret) begin
                    state_d   = ONE;
                    out_dat_d = skid_dat_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Ready is registered from the next state so it never depends on out_rdy combinationally.
        in_rdy_d = (state_d != FULL);
    end

    // Outputs
    always_comb begin
        out_vld = (state_q != EMPTY);
        in_rdy  = in_rdy_q;
        out_dat = out_dat_q;
    end

endmodule

// File: rtl/decoder2x4_pipe.sv
// decoder2x4_pipe: 2-to-4 one-hot decoder behind a two-entry skid buffer; optional
// per-line saturating hit counters under macro DECODER2X4_HIT_CNT_EN (adds hit_cnt port).
// Latency 1; in_ready registered, low only when both buffer entries hold words.
// Ports: clk, rst (async, active high), bus (decoder2x4_pipe_if.slave), [hit_cnt].
module decoder2x4_pipe
    import decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    decoder2x4_pipe_if.slave       bus
`ifdef DECODER2X4_HIT_CNT_EN
    ,
    output logic [LINES*CNT_W-1:0] hit_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decoder2x4_pipe: CNT_W must be at least 1");
    end

    dec_req_t         in_req;
    dec_req_t         out_req;
    logic             out_vld;
    logic             in_rdy;
    logic [LINES-1:0] onehot;

    assign in_req.en   = bus.in_en;
    assign in_req.code = bus.in_code;

    skid_buf #(
        .W($bits(dec_req_t))
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (bus.in_valid),
        .in_rdy  (in_rdy),
        .in_dat  (in_req),
        .out_vld (out_vld),
        .out_rdy (bus.out_ready),
        .out_dat (out_req)
    );

    // Decode after the buffer; an idle output reads as all-zero.
    assign onehot         = out_vld ? decode_onehot(out_req) : '0;
    assign bus.out_onehot = onehot;
    assign bus.out_valid  = out_vld;
    assign bus.in_ready   = in_rdy;

`ifdef DECODER2X4_HIT_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q [LINES];
    logic [CNT_W-1:0] hit_cnt_d [LINES];
    logic             retire;

    assign retire = out_vld && bus.out_ready;

    always_comb begin
        for (int k = 0; k < LINES; k++) begin
            hit_cnt_d[k] = hit_cnt_q[k];
            if (retire && onehot[k] && (hit_cnt_q[k] != {CNT_W{1'b1}})) begin
                hit_cnt_d[k] = hit_cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LINES; k++) begin
                hit_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LINES; k++) begin
                hit_cnt_q[k] <= hit_cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < LINES; k++) begin : g_hit_out
        assign hit_cnt[k*CNT_W +: CNT_W] = hit_cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_decoder2x4_pipe.sv
// Bench for decoder2x4_pipe: directed scenarios plus random valid/ready traffic
// checked against a queue-based reference model of the buffered word stream.
// Counter checks (and a CNT_W=2 saturation instance) exist when DECODER2X4_HIT_CNT_EN is set.
module tb_decoder2x4_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder2x4_pipe_if bus ();

`ifdef DECODER2X4_HIT_CNT_EN
    logic [31:0] hit_cnt;
    decoder2x4_pipe #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt));

    decoder2x4_pipe_if bus_sat ();
    logic [7:0] hit_cnt_sat;
    decoder2x4_pipe #(.CNT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(bus_sat), .hit_cnt(hit_cnt_sat));
    int hits_m [4];
`else
    decoder2x4_pipe #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int         tests;
    int         fails;
    logic [3:0] exp_q [$];
    logic       rdy_m;
    logic [3:0] lut [4];

    function automatic logic [3:0] ref_word(input logic en, input logic [1:0] code);
        return en ? lut[code] : 4'b0000;
    endfunction

    // Called at the sampling point (between edges): records the handshakes, crosses
    // the next rising edge, updates the model, returns 1 time unit after the edge.
    task automatic advance();
        logic       acc, ret, en;
        logic [1:0] code;
        logic [3:0] w;
        acc  = bus.in_valid && bus.in_ready;
        ret  = bus.out_valid && bus.out_ready;
        en   = bus.in_en;
        code = bus.in_code;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            rdy_m = 1'b0;
`ifdef DECODER2X4_HIT_CNT_EN
            for (int k = 0; k < 4; k++) hits_m[k] = 0;
`endif
        end else begin
            if (ret && exp_q.size() > 0) begin
                w = exp_q.pop_front();
`ifdef DECODER2X4_HIT_CNT_EN
                for (int k = 0; k < 4; k++) if (w[k] && hits_m[k] < 255) hits_m[k]++;
`endif
            end
            if (acc) exp_q.push_back(ref_word(en, code));
            rdy_m = (exp_q.size() < 2);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_code   = 2'b00;
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) begin @(negedge clk); advance(); end
        @(negedge clk);
        rst = 1'b0;
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) begin @(negedge clk); advance(); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        tests++; if (bus.out_onehot !== 4'b0000) begin fails++; $display("FAIL rst_onehot got=%b exp=0000", bus.out_onehot); end
`ifdef DECODER2X4_HIT_CNT_EN
        tests++; if (hit_cnt !== 32'h0) begin fails++; $display("FAIL rst_hit_cnt got=%h exp=0", hit_cnt); end
`endif
        rst = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rel_in_ready_pre got=%b exp=0", bus.in_ready); end
        advance();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready_post got=%b exp=1", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rel_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_single();
        bus.in_code = 2'b10; bus.in_en = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_pre_valid got=%b exp=0", bus.out_valid); end
        advance();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        tests++; if (bus.out_onehot !== 4'b0100) begin fails++; $display("FAIL single_onehot got=%b exp=0100", bus.out_onehot); end
        advance();
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_post_valid got=%b exp=0", bus.out_valid); end
        advance();
    endtask

    task automatic test_disable();
`ifdef DECODER2X4_HIT_CNT_EN
        int before [4];
        for (int k = 0; k < 4; k++) before[k] = hits_m[k];
`endif
        bus.in_code = 2'b11; bus.in_en = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        advance();
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL disable_valid got=%b exp=1", bus.out_valid); end
        tests++; if (bus.out_onehot !== 4'b0000) begin fails++; $display("FAIL disable_onehot got=%b exp=0000", bus.out_onehot); end
        advance();
`ifdef DECODER2X4_HIT_CNT_EN
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (hit_cnt[k*8 +: 8] !== 8'(before[k])) begin
                fails++; $display("FAIL disable_hit_cnt[%0d] got=%0d exp=%0d", k, hit_cnt[k*8 +: 8], before[k]);
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [3:0] got [$];
        logic [3:0] want [3];
        logic       sent;
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
        do_reset();
        bus.out_ready = 1'b0; bus.in_en = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_code = 2'(i);
            @(negedge clk);
            tests++;
            if (bus.in_ready !== (i < 2)) begin fails++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, (i < 2)); end
            advance();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            @(negedge clk);
            sent = bus.in_valid && bus.in_ready;
            if (bus.out_valid) got.push_back(bus.out_onehot);
            advance();
            if (sent) bus.in_valid = 1'b0;
        end
        tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== want[i]) begin fails++; $display("FAIL bp_word[%0d] got=%b exp=%b", i, got[i], want[i]); end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_code = 2'(i % 4);
            @(negedge clk);
            tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
            if (i > 0) begin
                tests++;
                if (bus.out_valid !== 1'b1 || bus.out_onehot !== lut[(i - 1) % 4]) begin
                    fails++; $display("FAIL stream_word[%0d] got=%b/%b exp=1/%b", i, bus.out_valid, bus.out_onehot, lut[(i - 1) % 4]);
                end
            end
            advance();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests++; if (bus.out_onehot !== 4'b1000) begin fails++; $display("FAIL stream_last got=%b exp=1000", bus.out_onehot); end
        advance();
`ifdef DECODER2X4_HIT_CNT_EN
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (hit_cnt[k*8 +: 8] !== 8'd4) begin fails++; $display("FAIL stream_hit_cnt[%0d] got=%0d exp=4", k, hit_cnt[k*8 +: 8]); end
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0; bus.in_en = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_code = 2'(i + 1);
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_full got rdy=%b vld=%b exp rdy=0 vld=1", bus.in_ready, bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got=%b exp=0", bus.in_ready); end
        advance();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        advance();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d] got=%b exp=0", i, bus.out_valid); end
            advance();
        end
`ifdef DECODER2X4_HIT_CNT_EN
        tests++; if (hit_cnt !== 32'h0) begin fails++; $display("FAIL mid_hit_cnt got=%h exp=0", hit_cnt); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] exp_w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_en     = ($urandom_range(0, 7) != 0);
            bus.in_code   = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_w = (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
            tests++; if (bus.in_ready !== rdy_m) begin fails++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", c, bus.in_ready, rdy_m); end
            tests++; if (bus.out_valid !== (exp_q.size() != 0)) begin fails++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", c, bus.out_valid, exp_q.size() != 0); end
            tests++; if (bus.out_onehot !== exp_w) begin fails++; $display("FAIL rnd_onehot[%0d] got=%b exp=%b", c, bus.out_onehot, exp_w); end
            advance();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) begin @(negedge clk); advance(); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rnd_drain got=%b exp=0", bus.out_valid); end
        advance();
`ifdef DECODER2X4_HIT_CNT_EN
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (hit_cnt[k*8 +: 8] !== 8'(hits_m[k])) begin fails++; $display("FAIL rnd_hit_cnt[%0d] got=%0d exp=%0d", k, hit_cnt[k*8 +: 8], hits_m[k]); end
        end
`endif
    endtask

`ifdef DECODER2X4_HIT_CNT_EN
    task automatic test_saturation();
        do_reset();
        bus_sat.in_code = 2'b01; bus_sat.in_en = 1'b1; bus_sat.in_valid = 1'b1; bus_sat.out_ready = 1'b1;
        repeat (5) begin @(negedge clk); advance(); end
        bus_sat.in_valid = 1'b0;
        repeat (2) begin @(negedge clk); advance(); end
        tests++; if (hit_cnt_sat[3:2] !== 2'b11) begin fails++; $display("FAIL sat_line1 got=%b exp=11", hit_cnt_sat[3:2]); end
        tests++;
        if (hit_cnt_sat[1:0] !== 2'b00 || hit_cnt_sat[7:4] !== 4'b0000) begin
            fails++; $display("FAIL sat_others got=%b exp=00000000 outside [3:2]", hit_cnt_sat);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rdy_m = 1'b0;
        lut[0] = 4'b0001; lut[1] = 4'b0010; lut[2] = 4'b0100; lut[3] = 4'b1000;
        rst = 1'b1;
        idle_inputs();
`ifdef DECODER2X4_HIT_CNT_EN
        for (int k = 0; k < 4; k++) hits_m[k] = 0;
        bus_sat.in_valid = 1'b0; bus_sat.in_code = 2'b00; bus_sat.in_en = 1'b0; bus_sat.out_ready = 1'b0;
`endif
        test_reset();
        test_single();
        test_disable();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random();
`ifdef DECODER2X4_HIT_CNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decoder2x4_pipe.md
DECODER2X4_PIPE -- requirements
Module: decoder2x4_pipe

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of each per-line hit counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  an input code is offered.
REQ-005 SHALL have port in_ready  output  1  the block can accept a code this cycle.
REQ-006 SHALL have port in_code  input  2  binary code to decode.
REQ-007 SHALL have port in_en  input  1  decode enable, sampled with in_code.
REQ-008 SHALL have port out_valid  output  1  out_onehot holds a decoded word.
REQ-009 SHALL have port out_ready  input  1  the downstream consumer accepts the word.
REQ-010 SHALL have port out_onehot  output  4  decoded word: bit in_code set when enabled, else 4'b0000.
REQ-011 SHALL have port hit_cnt  output  4*CNT_W  packed per-line counters, line k at bits [k*CNT_W +: CNT_W]; present only under REQ-024.

Function
REQ-012 SHALL accept a code on a rising edge where in_valid && in_ready, and never otherwise.
REQ-013 SHALL decode as: 00->0001, 01->0010, 10->0100, 11->1000; in_en=0 -> 0000 whatever the code.
REQ-014 SHALL present an accepted word with out_valid=1 after one edge (latency 1) when the output stage is empty or draining.
REQ-015 SHALL retire the output word on an edge where out_valid && out_ready, and hold out_onehot stable while out_valid && !out_ready.
REQ-016 SHALL implement a two-entry skid buffer with states EMPTY, ONE and FULL: EMPTY->ONE on accept; ONE->FULL on accept without retire; ONE->EMPTY on retire without accept; ONE stays ONE on simultaneous accept and retire; FULL->ONE on retire, with the skid word moving to output.
REQ-017 SHALL drive in_ready from a register, equal to 1 in states EMPTY and ONE and 0 in state FULL, with no combinational path from out_ready.
REQ-018 SHALL preserve order, with no loss or duplication of words under any valid/ready pattern.
REQ-019 SHALL not change state or outputs on an edge where in_valid=0 and out_ready=0.

Reset
REQ-020 SHALL, while rst=1, force state EMPTY, out_valid=0, out_onehot=4'b0000, in_ready=0, and every hit_cnt field to 0.
REQ-021 SHALL set in_ready=1 on the first rising edge after rst deasserts.
REQ-022 SHALL discard any buffered words when reset is asserted mid-operation, presenting none after release.

Configuration
REQ-023 SHALL use the macro DECODER2X4_HIT_CNT_EN.
REQ-024 SHALL, when DECODER2X4_HIT_CNT_EN is defined, increment hit_cnt field k by 1 on each retire of a word with bit k set, saturating at 2^CNT_W-1, with no increment for 0000 words.
REQ-025 SHALL, when DECODER2X4_HIT_CNT_EN is undefined, omit the hit_cnt port and counter logic entirely, with all other behaviour identical.

Structure
REQ-026 SHALL take from shared package decoder_pkg the state enum (EMPTY/ONE/FULL), the constants CODE_W=2 and LINES=4, and the one-hot decode function.
REQ-027 SHALL place the datapath-independent elastic buffer in sub-module skid_buf (parameterised width; carries {en, code}), with decoding performed at its output.

Verification
REQ-028 SHALL verify single transfer: after reset, drive in_code=2'b10, in_en=1, in_valid=1 for one cycle with out_ready=1 -> out_valid=1 with out_onehot=4'b0100 exactly one cycle later, then out_valid=0.
REQ-029 SHALL verify disable: drive in_code=2'b11, in_en=0 -> out_onehot=4'b0000 with out_valid=1, and hit_cnt unchanged.
REQ-030 SHALL verify backpressure: send codes 00, 01, 10 back-to-back with out_ready=0 -> in_ready drops after the 2nd accept; after out_ready=1, the outputs are 0001, 0010, 0100 in order.
REQ-031 SHALL verify streaming: hold in_valid=out_ready=1 for 16 cycles with codes cycling 0..3 -> one word per cycle, in_ready stays 1, and each hit_cnt field reaches 4.
REQ-032 SHALL verify reset mid-operation: assert rst while in state FULL -> out_valid=0 and in_ready=0 immediately; after release, no stale word appears and hit_cnt=0.
REQ-033 SHALL verify saturation with CNT_W=2: retire code 01 five times -> hit_cnt[3:2]=2'b11 and the other fields are 0.
